// File: rtl/dbi_tx_arb_if.sv
// dbi_tx_arb_if -- requester and PHY handshake bundle for dbi_tx_arb.
//   r0_* / r1_*   : requester beats (hrst, cmd_typ, cmd_dat, last, no_dat, vld)
//                   and their rdy_o acceptance
//   dtp_tx_rdy_i  : PHY ready
//   dtp_*_o       : beat forwarded to the DBI TX PHY
// Modports: slave = arbiter view, master = requester/PHY (environment) view.
interface dbi_tx_arb_if #(
  parameter int unsigned DBI_IF_D_W = 8
);
  logic                  r0_hrst_i;
  logic [DBI_IF_D_W-1:0] r0_cmd_typ_i;
  logic [DBI_IF_D_W-1:0] r0_cmd_dat_i;
  logic                  r0_last_i;
  logic                  r0_no_dat_i;
  logic                  r0_vld_i;
  logic                  r0_rdy_o;

  logic                  r1_hrst_i;
  logic [DBI_IF_D_W-1:0] r1_cmd_typ_i;
  logic [DBI_IF_D_W-1:0] r1_cmd_dat_i;
  logic                  r1_last_i;
  logic                  r1_no_dat_i;
  logic                  r1_vld_i;
  logic                  r1_rdy_o;

  logic                  dtp_tx_rdy_i;
  logic                  dtp_dbi_hrst_o;
  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o;
  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o;
  logic                  dtp_tx_last_o;
  logic                  dtp_tx_no_dat_o;
  logic                  dtp_tx_vld_o;

  modport slave (
    input  r0_hrst_i, r0_cmd_typ_i, r0_cmd_dat_i, r0_last_i, r0_no_dat_i, r0_vld_i,
    output r0_rdy_o,
    input  r1_hrst_i, r1_cmd_typ_i, r1_cmd_dat_i, r1_last_i, r1_no_dat_i, r1_vld_i,
    output r1_rdy_o,
    input  dtp_tx_rdy_i,
    output dtp_dbi_hrst_o, dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_last_o,
           dtp_tx_no_dat_o, dtp_tx_vld_o
  );

  modport master (
    output r0_hrst_i, r0_cmd_typ_i, r0_cmd_dat_i, r0_last_i, r0_no_dat_i, r0_vld_i,
    input  r0_rdy_o,
    output r1_hrst_i, r1_cmd_typ_i, r1_cmd_dat_i, r1_last_i, r1_no_dat_i, r1_vld_i,
    input  r1_rdy_o,
    output dtp_tx_rdy_i,
    input  dtp_dbi_hrst_o, dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_last_o,
           dtp_tx_no_dat_o, dtp_tx_vld_o
  );
endinterface

// File: rtl/dbi_tx_arb.sv
// dbi_tx_arb -- packet-atomic two-requester arbiter for the DBI TX PHY port.
//   r0 = frame-streaming FSM, r1 = software command path.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dbi_tx_arb_if.slave (requester beats in, PHY beat out)
//   gnt_o      : one-hot current lock {r1,r0}, 2'b00 when idle
//   tmo_o      : one-cycle pulse when a stalled lock is forcibly released
// Build option: define DBI_TX_ARB_RR_EN for round-robin tie-breaking;
// otherwise r1 always wins a tie (fixed priority, no pointer register).
module dbi_tx_arb #(
  parameter int unsigned DBI_IF_D_W   = 8,
  parameter int unsigned LOCK_TMO_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  dbi_tx_arb_if.slave        bus,
  output logic [1:0]         gnt_o,
  output logic               tmo_o
);

  localparam int unsigned CNT_W    = $clog2(LOCK_TMO_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  tmo_hit;
  logic                  tie_r1;

  // Beat of the currently locked requester (all zero when idle).
  logic                  g_hrst, g_last, g_no_dat, g_vld;
  logic [DBI_IF_D_W-1:0] g_typ, g_dat;

`ifdef DBI_TX_ARB_RR_EN
  logic last_r1;  // 1: most recent grant went to r1

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r1 <= 1'b1;
    end else if (state == IDLE && state_nxt == LOCK0) begin
      last_r1 <= 1'b0;
    end else if (state == IDLE && state_nxt == LOCK1) begin
      last_r1 <= 1'b1;
    end
  end

  assign tie_r1 = ~last_r1;
`else
  assign tie_r1 = 1'b1;
`endif

  always_comb begin : grant_mux
    g_hrst   = 1'b0;
    g_last   = 1'b0;
    g_no_dat = 1'b0;
    g_vld    = 1'b0;
    g_typ    = '0;
    g_dat    = '0;
    case (state)
      LOCK0: begin
        g_hrst   = bus.r0_hrst_i;
        g_last   = bus.r0_last_i;
        g_no_dat = bus.r0_no_dat_i;
        g_vld    = bus.r0_vld_i;
        g_typ    = bus.r0_cmd_typ_i;
        g_dat    = bus.r0_cmd_dat_i;
      end
      LOCK1: begin
        g_hrst   = bus.r1_hrst_i;
        g_last   = bus.r1_last_i;
        g_no_dat = bus.r1_no_dat_i;
        g_vld    = bus.r1_vld_i;
        g_typ    = bus.r1_cmd_typ_i;
        g_dat    = bus.r1_cmd_dat_i;
      end
      default: ;
    endcase
  end

  // State register; the stall counter runs only while locked with vld low
  // and is zeroed whenever the lock is absent or about to be dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || state_nxt == IDLE || g_vld) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.r0_vld_i && bus.r1_vld_i) begin
          state_nxt = tie_r1 ? LOCK1 : LOCK0;
        end else if (bus.r0_vld_i) begin
          state_nxt = LOCK0;
        end else if (bus.r1_vld_i) begin
          state_nxt = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        if (g_vld && bus.dtp_tx_rdy_i && (g_last || g_hrst)) begin
          state_nxt = IDLE;
        end else if (!g_vld && tmo_cnt == TMO_LAST) begin
          state_nxt = IDLE;
          tmo_hit   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : outputs
    bus.dtp_dbi_hrst_o   = g_hrst;
    bus.dtp_tx_cmd_typ_o = g_typ;
    bus.dtp_tx_cmd_dat_o = g_dat;
    bus.dtp_tx_last_o    = g_last;
    bus.dtp_tx_no_dat_o  = g_no_dat;
    bus.dtp_tx_vld_o     = g_vld;
    bus.r0_rdy_o         = (state == LOCK0) && bus.dtp_tx_rdy_i;
    bus.r1_rdy_o         = (state == LOCK1) && bus.dtp_tx_rdy_i;
    gnt_o                = {state == LOCK1, state == LOCK0};
    tmo_o                = tmo_hit;
  end

endmodule

// File: tb/tb_dbi_tx_arb.sv
// tb_dbi_tx_arb -- directed, table-driven bench for dbi_tx_arb (LOCK_TMO_CYC=8).
// Each record is one clock cycle: requester/PHY inputs plus the hand-computed
// grant and timeout expected during that cycle. Requester cmd_dat is driven as
// ~cmd_typ and no_dat as cmd_typ[0] so every forwarded field is distinguishable.
module tb_dbi_tx_arb;

  typedef struct {
    string      name;
    logic       r0v, r0l, r0h;
    logic [7:0] r0t;
    logic       r1v, r1l, r1h;
    logic [7:0] r1t;
    logic       rdy;
    logic [1:0] egnt;
    logic       etmo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] gnt;
  logic tmo;
  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  dbi_tx_arb_if #(.DBI_IF_D_W(8)) bus ();

  dbi_tx_arb #(.DBI_IF_D_W(8), .LOCK_TMO_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .gnt_o (gnt),
    .tmo_o (tmo)
  );

  function automatic vec_t mk(input string n,
                              input logic r0v, input logic r0l, input logic r0h, input logic [7:0] r0t,
                              input logic r1v, input logic r1l, input logic r1h, input logic [7:0] r1t,
                              input logic rdy, input logic [1:0] egnt, input logic etmo);
    vec_t v;
    v.name = n;
    v.r0v = r0v; v.r0l = r0l; v.r0h = r0h; v.r0t = r0t;
    v.r1v = r1v; v.r1l = r1l; v.r1h = r1h; v.r1t = r1t;
    v.rdy = rdy; v.egnt = egnt; v.etmo = etmo;
    return v;
  endfunction

  function automatic void add(input string n,
                              input logic r0v, input logic r0l, input logic r0h, input logic [7:0] r0t,
                              input logic r1v, input logic r1l, input logic r1h, input logic [7:0] r1t,
                              input logic rdy, input logic [1:0] egnt, input logic etmo);
    vq.push_back(mk(n, r0v, r0l, r0h, r0t, r1v, r1l, r1h, r1t, rdy, egnt, etmo));
  endfunction

  task automatic apply(input vec_t v);
    bus.r0_vld_i     = v.r0v;
    bus.r0_last_i    = v.r0l;
    bus.r0_hrst_i    = v.r0h;
    bus.r0_cmd_typ_i = v.r0t;
    bus.r0_cmd_dat_i = ~v.r0t;
    bus.r0_no_dat_i  = v.r0t[0];
    bus.r1_vld_i     = v.r1v;
    bus.r1_last_i    = v.r1l;
    bus.r1_hrst_i    = v.r1h;
    bus.r1_cmd_typ_i = v.r1t;
    bus.r1_cmd_dat_i = ~v.r1t;
    bus.r1_no_dat_i  = v.r1t[0];
    bus.dtp_tx_rdy_i = v.rdy;
  endtask

  task automatic chk(input string vn, input string fld, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s.%s: got %h want %h", vn, fld, act, exp);
    end
  endtask

  // Expected PHY beat is the locked requester's beat; nothing when unlocked.
  task automatic check_vec(input vec_t v);
    logic       e_vld, e_last, e_hrst, e_nd, e_r0rdy, e_r1rdy;
    logic [7:0] e_typ, e_dat;
    e_vld = 0; e_last = 0; e_hrst = 0; e_nd = 0; e_r0rdy = 0; e_r1rdy = 0;
    e_typ = '0; e_dat = '0;
    if (v.egnt == 2'b01) begin
      e_vld = v.r0v; e_last = v.r0l; e_hrst = v.r0h;
      e_typ = v.r0t; e_dat = ~v.r0t; e_nd = v.r0t[0]; e_r0rdy = v.rdy;
    end else if (v.egnt == 2'b10) begin
      e_vld = v.r1v; e_last = v.r1l; e_hrst = v.r1h;
      e_typ = v.r1t; e_dat = ~v.r1t; e_nd = v.r1t[0]; e_r1rdy = v.rdy;
    end
    n_vec++;
    chk(v.name, "gnt",    {6'd0, gnt},                v.egnt);
    chk(v.name, "tmo",    {7'd0, tmo},                v.etmo);
    chk(v.name, "r0_rdy", {7'd0, bus.r0_rdy_o},       e_r0rdy);
    chk(v.name, "r1_rdy", {7'd0, bus.r1_rdy_o},       e_r1rdy);
    chk(v.name, "vld",    {7'd0, bus.dtp_tx_vld_o},   e_vld);
    chk(v.name, "last",   {7'd0, bus.dtp_tx_last_o},  e_last);
    chk(v.name, "hrst",   {7'd0, bus.dtp_dbi_hrst_o}, e_hrst);
    chk(v.name, "no_dat", {7'd0, bus.dtp_tx_no_dat_o}, e_nd);
    chk(v.name, "typ",    bus.dtp_tx_cmd_typ_o,       e_typ);
    chk(v.name, "dat",    bus.dtp_tx_cmd_dat_o,       e_dat);
  endtask

  initial begin
    vec_t v;

    // r0 alone: 4-beat packet, PHY always ready
    add("t1_idle",  1,0,0,8'h2A, 0,0,0,8'h00, 1, 2'b00, 0);
    add("t1_b1",    1,0,0,8'h2A, 0,0,0,8'h00, 1, 2'b01, 0);
    add("t1_b2",    1,0,0,8'h2B, 0,0,0,8'h00, 1, 2'b01, 0);
    add("t1_b3",    1,0,0,8'h2C, 0,0,0,8'h00, 1, 2'b01, 0);
    add("t1_b4",    1,1,0,8'h2D, 0,0,0,8'h00, 1, 2'b01, 0);
    add("t1_done",  0,0,0,8'h00, 0,0,0,8'h00, 1, 2'b00, 0);
    // PHY backpressure 1010 while r0 holds each unaccepted beat
    add("bp_idle",  1,0,0,8'h40, 0,0,0,8'h00, 1, 2'b00, 0);
    add("bp_b1",    1,0,0,8'h40, 0,0,0,8'h00, 1, 2'b01, 0);
    add("bp_st1",   1,0,0,8'h41, 0,0,0,8'h00, 0, 2'b01, 0);
    add("bp_b2",    1,0,0,8'h41, 0,0,0,8'h00, 1, 2'b01, 0);
    add("bp_st2",   1,1,0,8'h42, 0,0,0,8'h00, 0, 2'b01, 0);
    add("bp_b3",    1,1,0,8'h42, 0,0,0,8'h00, 1, 2'b01, 0);
    add("bp_done",  0,0,0,8'h00, 0,0,0,8'h00, 1, 2'b00, 0);
    // r1 single hard-reset beat, last=0 still terminates
    add("hr_idle",  0,0,0,8'h00, 1,0,1,8'h5A, 1, 2'b00, 0);
    add("hr_beat",  0,0,0,8'h00, 1,0,1,8'h5A, 1, 2'b10, 0);
    add("hr_done",  0,0,0,8'h00, 0,0,0,8'h00, 1, 2'b00, 0);
    // tie: both requesters stream 2-beat packets continuously
`ifdef DBI_TX_ARB_RR_EN
    add("tie_i0",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b00, 0);
    add("tie_a1",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b01, 0);
    add("tie_a2",   1,1,0,8'h11, 1,0,0,8'h20, 1, 2'b01, 0);
    add("tie_i1",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b00, 0);
    add("tie_b1",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b10, 0);
    add("tie_b2",   1,0,0,8'h10, 1,1,0,8'h21, 1, 2'b10, 0);
    add("tie_i2",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b00, 0);
    add("tie_c1",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b01, 0);
    add("tie_c2",   1,1,0,8'h11, 1,0,0,8'h20, 1, 2'b01, 0);
`else
    add("tie_i0",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b00, 0);
    add("tie_a1",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b10, 0);
    add("tie_a2",   1,0,0,8'h10, 1,1,0,8'h21, 1, 2'b10, 0);
    add("tie_i1",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b00, 0);
    add("tie_b1",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b10, 0);
    add("tie_b2",   1,0,0,8'h10, 1,1,0,8'h21, 1, 2'b10, 0);
    add("tie_i2",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b00, 0);
    add("tie_c1",   1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b10, 0);
    add("tie_c2",   1,0,0,8'h10, 1,1,0,8'h21, 1, 2'b10, 0);
`endif
    add("tie_done", 0,0,0,8'h00, 0,0,0,8'h00, 1, 2'b00, 0);
    // timeout: one r0 beat, then vld low for 8 cycles while r1 waits
    add("to_idle",  1,0,0,8'h33, 0,0,0,8'h00, 1, 2'b00, 0);
    add("to_beat",  1,0,0,8'h33, 0,0,0,8'h00, 1, 2'b01, 0);
    for (int k = 0; k < 7; k++)
      add("to_gap", 0,0,0,8'h00, 1,1,0,8'h77, 1, 2'b01, 0);
    add("to_tmo",   0,0,0,8'h00, 1,1,0,8'h77, 1, 2'b01, 1);
    add("to_idle2", 0,0,0,8'h00, 1,1,0,8'h77, 1, 2'b00, 0);
    add("to_r1",    0,0,0,8'h00, 1,1,0,8'h77, 1, 2'b10, 0);
    add("to_done",  0,0,0,8'h00, 0,0,0,8'h00, 1, 2'b00, 0);

    // reset state, with both requesters asserting vld
    rst_n = 1'b0;
    v = mk("rst", 1,0,0,8'h12, 1,0,0,8'h34, 1, 2'b00, 0);
    apply(v);
    repeat (2) @(negedge clk);
    #1 check_vec(v);
    apply(mk("rel", 0,0,0,8'h00, 0,0,0,8'h00, 1, 2'b00, 0));
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      apply(vq[i]);
      #1 check_vec(vq[i]);
    end

    // asynchronous reset mid-packet while locked to r1
    @(negedge clk);
    v = mk("mr_idle", 0,0,0,8'h00, 1,0,0,8'h66, 1, 2'b00, 0);
    apply(v);
    #1 check_vec(v);
    @(negedge clk);
    v = mk("mr_lock", 0,0,0,8'h00, 1,0,0,8'h66, 1, 2'b10, 0);
    apply(v);
    #1 check_vec(v);
    #2 rst_n = 1'b0;
    v.name = "mr_async";
    v.egnt = 2'b00;
    #1 check_vec(v);
    @(negedge clk);
    v = mk("mr_held", 1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b00, 0);
    apply(v);
    #1 check_vec(v);
    @(negedge clk);
    rst_n = 1'b1;
    v.name = "mr_rel";
    #1 check_vec(v);
    @(negedge clk);
`ifdef DBI_TX_ARB_RR_EN
    v = mk("mr_tie", 1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b01, 0);
`else
    v = mk("mr_tie", 1,0,0,8'h10, 1,0,0,8'h20, 1, 2'b10, 0);
`endif
    #1 check_vec(v);

    @(negedge clk);
    apply(mk("end", 0,0,0,8'h00, 0,0,0,8'h00, 1, 2'b00, 0));
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/dbi_tx_arb.md
# dbi_tx_arb

Two-requester arbiter that shares the single DBI TX PHY command/data port between the frame-streaming FSM (requester 0) and the software command path (requester 1). Grants are packet-atomic: once a requester is granted, only its beats reach the PHY until a packet-terminating handshake completes or the lock times out. It sits between the requesters and the DBI TX PHY and adds no buffering; only grant state is registered.

## Interface
- DBI_IF_D_W, 8, command type/data width
- LOCK_TMO_CYC, 1024, consecutive cycles of granted vld=0 mid-packet before the lock is forcibly released (≥2)

- clk  in  1  internal clock
- rst_n  in  1  reset; asynchronous, active-low
- r0_hrst_i / r1_hrst_i  in  1  requester hard-reset request beat
- r0_cmd_typ_i / r1_cmd_typ_i  in  DBI_IF_D_W  command type
- r0_cmd_dat_i / r1_cmd_dat_i  in  DBI_IF_D_W  command data
- r0_last_i / r1_last_i  in  1  last beat of packet
- r0_no_dat_i / r1_no_dat_i  in  1  command without data phase
- r0_vld_i / r1_vld_i  in  1  beat valid
- r0_rdy_o / r1_rdy_o  out  1  beat accepted
- dtp_tx_rdy_i  in  1  PHY ready
- dtp_dbi_hrst_o, dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_last_o, dtp_tx_no_dat_o, dtp_tx_vld_o  out  1/DBI_IF_D_W/DBI_IF_D_W/1/1/1  to PHY
- gnt_o  out  2  one-hot current lock ({r1,r0}); 2'b00 when idle
- tmo_o  out  1  one-cycle pulse on lock timeout

## Operation
- States: IDLE, LOCK0, LOCK1 (registered, async reset to IDLE).
- IDLE: all PHY outputs 0, both rdy_o 0. If any rX_vld_i=1, next state is LOCKx of the winner; otherwise stay.
- Winner: only one requesting → that one. Both requesting → per arbitration policy (Configuration).
- LOCKx: PHY outputs = requester x inputs combinationally; rx_rdy_o = dtp_tx_rdy_i; other requester's rdy_o = 0.
- End of packet: handshake (rx_vld_i & dtp_tx_rdy_i) with rx_last_i=1 or rx_hrst_i=1 → IDLE. hrst beat is always single-beat terminating.
- Timeout counter (width $clog2(LOCK_TMO_CYC)): cleared on entering LOCKx and on any cycle with rx_vld_i=1; increments when rx_vld_i=0. When it equals LOCK_TMO_CYC-1 with vld=0 → IDLE next cycle, tmo_o=1 for that cycle.
- Packets are never interleaved; the non-granted requester waits with vld held.
- Beat counts are not checked; packet length is owned by the requesters.

## Timing
- Arbitration latency: 1 cycle (IDLE cycle decides, LOCK cycle forwards). Back-to-back packets incur exactly one IDLE bubble.
- Datapath latency in LOCKx: 0 cycles (combinational pass-through, rdy combinational from dtp_tx_rdy_i).
- Reset values: state IDLE, all outputs 0, timeout counter 0, RR pointer = r1 (so first tie goes to r0).
- Reset asserted mid-packet: immediate return to IDLE, outputs 0; the partial packet is abandoned, no tmo_o.
- Termination handshake and timeout cannot coincide (timeout requires vld=0).
- A requester dropping vld mid-packet without timeout keeps the lock; PHY sees vld=0.
- tmo_o asserted only in the LOCKx cycle that transitions to IDLE.

## Configuration
- DBI_TX_ARB_RR_EN defined: round-robin; on a tie in IDLE the requester not granted last wins; pointer updates on every grant.
- Not defined: fixed priority; on a tie r1 (software command) always wins; no pointer register.

## Test plan
- Reset, r0 only: r0 sends 4-beat packet (cmd_typ 8'h2A, last on beat 4), PHY rdy=1 → gnt_o=01 one cycle after vld, 4 PHY beats, IDLE on cycle after 4th, r1_rdy_o=0 throughout.
- Tie: both vld from same cycle, 2-beat packets each → RR build: r0, bubble, r1, bubble, r0; fixed build: r1 first and r1 again while it keeps requesting.
- Backpressure: dtp_tx_rdy_i toggling 1010 in LOCK0 → r0_rdy_o mirrors rdy, beats never duplicated or dropped, lock held until last handshake.
- hrst: r1 single beat hrst=1, last=0 → dtp_dbi_hrst_o=1, lock released after that one handshake.
- Timeout with LOCK_TMO_CYC=8: r0 sends 1 beat (last=0) then drops vld → tmo_o pulses exactly 8 cycles after last vld, gnt_o→00, r1 pending gets LOCK1 next cycle.
- rst_n pulled low mid-packet in LOCK1 → all outputs 0 asynchronously, gnt_o=00; after release, new tie goes to r0 (RR build).
